// File: rtl/ucode_sequencer.sv
// Micro-op sequencer for the SM83 core: instruction register, step counter, CB-prefix tracking,
// HALT and interrupt dispatch. All outputs are registered.
module ucode_sequencer #(
  parameter int unsigned  STEP_W     = 3,
  parameter int unsigned  MAX_STEP   = 5,
  parameter int unsigned  IRQ_N      = 5,
  parameter logic [7:0]   IRQ_OPCODE = 8'hD3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [7:0]        db_in,
  input  logic              done,
  input  logic              is_cond,
  input  logic [STEP_W-1:0] next_cond,
  input  logic [3:0]        flags,
  input  logic              ime,
  input  logic [IRQ_N-1:0]  irq_pending,
  output logic [7:0]        opcode,
  output logic              cb_mode,
  output logic [STEP_W-1:0] step,
  output logic              irq_dispatch,
  output logic [7:0]        irq_vec,
  output logic [IRQ_N-1:0]  irq_ack,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned IdxW = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e              state_q;
  logic [7:0]          opcode_q;
  logic                cb_mode_q;
  logic [STEP_W-1:0]   step_q;
  logic                irq_dispatch_q;
  logic [7:0]          irq_vec_q;
  logic [IRQ_N-1:0]    irq_ack_q;
  logic                halted_q;
  logic                illegal_q;

  logic                cc_true;
  logic [IdxW-1:0]     irq_idx;
  logic                irq_any;
  logic                seq_end;
  logic                cb_prefix;

  // Only Z (bit 3) and C (bit 0) select conditional branches.
  logic unused_flags;
  assign unused_flags = ^flags[2:1];

  always_comb begin
    cc_true = 1'b0;
    unique case (opcode_q[4:3])
      2'd0: cc_true = !flags[3];
      2'd1: cc_true = flags[3];
      2'd2: cc_true = !flags[0];
      2'd3: cc_true = flags[0];
      default: cc_true = 1'b0;
    endcase
  end

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    irq_idx = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (irq_pending[i]) irq_idx = IdxW'(i);
    end
  end

  assign irq_any   = |irq_pending;
  assign seq_end   = done || (step_q == STEP_W'(MAX_STEP));
  assign cb_prefix = (opcode_q == 8'hCB) && !cb_mode_q && !irq_dispatch_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      opcode_q       <= 8'h00;
      cb_mode_q      <= 1'b0;
      step_q         <= '0;
      irq_dispatch_q <= 1'b0;
      irq_vec_q      <= 8'h40;
      irq_ack_q      <= '0;
      halted_q       <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      irq_ack_q <= '0;
      if (!stall) begin
        unique case (state_q)
          StRun: begin
            if (seq_end) begin
              if (!done) illegal_q <= 1'b1;
              step_q <= '0;
              if ((opcode_q == 8'h76) && !cb_mode_q && !irq_dispatch_q && !irq_any) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
              end else if (ime && irq_any && !((opcode_q == 8'hCB) && !cb_mode_q)) begin
                opcode_q       <= IRQ_OPCODE;
                irq_dispatch_q <= 1'b1;
                cb_mode_q      <= 1'b0;
                irq_vec_q      <= 8'h40 + (8'(irq_idx) << 3);
                irq_ack_q      <= IRQ_N'(1) << irq_idx;
              end else begin
                opcode_q       <= db_in;
                irq_dispatch_q <= 1'b0;
                cb_mode_q      <= cb_prefix;
              end
            end else if (is_cond && !cc_true) begin
              step_q <= next_cond;
            end else begin
              step_q <= step_q + STEP_W'(1);
            end
          end
          StHalt: begin
            if (irq_any) begin
              state_q  <= StRun;
              halted_q <= 1'b0;
              step_q   <= '0;
              if (ime) begin
                opcode_q       <= IRQ_OPCODE;
                irq_dispatch_q <= 1'b1;
                cb_mode_q      <= 1'b0;
                irq_vec_q      <= 8'h40 + (8'(irq_idx) << 3);
                irq_ack_q      <= IRQ_N'(1) << irq_idx;
              end else begin
                // Resume on a NOP: its done cycle refetches from the bus.
                opcode_q <= 8'h00;
              end
            end
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign opcode       = opcode_q;
  assign cb_mode      = cb_mode_q;
  assign step         = step_q;
  assign irq_dispatch = irq_dispatch_q;
  assign irq_vec      = irq_vec_q;
  assign irq_ack      = irq_ack_q;
  assign halted       = halted_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios with literal expectations, then randomized
// stimulus compared every cycle against a behavioural model.
module tb_ucode_sequencer;

  localparam int STEP_W   = 3;
  localparam int MAX_STEP = 5;
  localparam int IRQ_N    = 5;

  logic              clk = 1'b0;
  logic              rst_n, stall, done, is_cond, ime;
  logic [7:0]        db_in;
  logic [STEP_W-1:0] next_cond;
  logic [3:0]        flags;
  logic [IRQ_N-1:0]  irq_pending;
  logic [7:0]        opcode, irq_vec;
  logic              cb_mode, irq_dispatch, halted, illegal;
  logic [STEP_W-1:0] step;
  logic [IRQ_N-1:0]  irq_ack;

  ucode_sequencer #(
    .STEP_W(STEP_W), .MAX_STEP(MAX_STEP), .IRQ_N(IRQ_N), .IRQ_OPCODE(8'hD3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .db_in(db_in), .done(done), .is_cond(is_cond),
    .next_cond(next_cond), .flags(flags), .ime(ime), .irq_pending(irq_pending),
    .opcode(opcode), .cb_mode(cb_mode), .step(step), .irq_dispatch(irq_dispatch),
    .irq_vec(irq_vec), .irq_ack(irq_ack), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model state: plain integers updated from the architectural rules.
  int m_opcode, m_step, m_vec, m_ack;
  bit m_cb, m_disp, m_halted, m_illegal;
  int n_opcode, n_step, n_vec, n_ack;
  bit n_cb, n_disp, n_halted, n_illegal;

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit cond_holds(int op, logic [3:0] f);
    int sel = (op / 8) % 4;
    bit flag = (sel >= 2) ? f[0] : f[3];
    return flag == bit'(sel % 2);
  endfunction

  function automatic int lowest_irq(int pend);
    for (int i = 0; i < IRQ_N; i++) if (((pend >> i) & 1) == 1) return i;
    return -1;
  endfunction

  task automatic model_dispatch();
    int i = lowest_irq(int'(irq_pending));
    n_opcode = 'hD3;
    n_disp   = 1'b1;
    n_cb     = 1'b0;
    n_vec    = 'h40 + 8 * i;
    n_ack    = 1 << i;
  endtask

  task automatic model_edge();
    bit pend = (irq_pending != 0);
    n_opcode = m_opcode; n_step = m_step; n_vec = m_vec; n_ack = 0;
    n_cb = m_cb; n_disp = m_disp; n_halted = m_halted; n_illegal = m_illegal;
    if (!rst_n) begin
      n_opcode = 0; n_step = 0; n_vec = 'h40; n_ack = 0;
      n_cb = 0; n_disp = 0; n_halted = 0; n_illegal = 0;
    end else if (!stall) begin
      if (!m_halted) begin
        bit forced = !done && (m_step == MAX_STEP);
        if (done || forced) begin
          if (forced) n_illegal = 1'b1;
          n_step = 0;
          if (m_opcode == 'h76 && !m_cb && !m_disp && !pend) n_halted = 1'b1;
          else if (ime && pend && !(m_opcode == 'hCB && !m_cb)) model_dispatch();
          else begin
            n_cb     = (m_opcode == 'hCB) && !m_cb && !m_disp;
            n_opcode = int'(db_in);
            n_disp   = 1'b0;
          end
        end else if (is_cond && !cond_holds(m_opcode, flags)) begin
          n_step = int'(next_cond);
        end else begin
          n_step = (m_step + 1) % (1 << STEP_W);
        end
      end else if (pend) begin
        n_halted = 1'b0;
        n_step   = 0;
        if (ime) model_dispatch();
        else n_opcode = 0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    m_opcode = n_opcode; m_step = n_step; m_vec = n_vec; m_ack = n_ack;
    m_cb = n_cb; m_disp = n_disp; m_halted = n_halted; m_illegal = n_illegal;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("opcode", int'(opcode), m_opcode);
      check("step", int'(step), m_step);
      check("cb_mode", int'(cb_mode), int'(m_cb));
      check("irq_dispatch", int'(irq_dispatch), int'(m_disp));
      check("irq_vec", int'(irq_vec), m_vec);
      check("irq_ack", int'(irq_ack), m_ack);
      check("halted", int'(halted), int'(m_halted));
      check("illegal", int'(illegal), int'(m_illegal));
    end
  end

  initial begin
    logic [7:0] picks [6];
    picks[0] = 8'h76; picks[1] = 8'hCB; picks[2] = 8'h28;
    picks[3] = 8'h00; picks[4] = 8'h38; picks[5] = 8'hC2;

    rst_n = 0; stall = 0; done = 0; is_cond = 0; ime = 0;
    db_in = 8'h00; next_cond = '0; flags = 4'h0; irq_pending = '0;
    @(negedge clk);
    tick();
    chk_en = 1'b1;
    check("rst opcode", int'(opcode), 'h00);
    check("rst irq_vec", int'(irq_vec), 'h40);
    check("rst step", int'(step), 0);
    rst_n = 1;

    // Basic fetch and step advance.
    done = 1; db_in = 8'h3E; tick();
    check("fetch 3E", int'(opcode), 'h3E);
    done = 0; tick();
    check("step 1", int'(step), 1);
    done = 1; db_in = 8'h00; tick();
    check("fetch 00", int'(opcode), 'h00);
    check("fetch step 0", int'(step), 0);

    // Conditional step on JR Z.
    db_in = 8'h28; tick();
    done = 0; is_cond = 1; next_cond = 3; flags = 4'b0000; tick();
    check("cond fail step", int'(step), 3);
    done = 1; is_cond = 0; tick();
    done = 0; is_cond = 1; flags = 4'b1000; tick();
    check("cond pass step", int'(step), 1);
    is_cond = 0; flags = 4'h0;

    // CB prefix blocks dispatch for its second byte.
    done = 1; db_in = 8'hCB; tick();
    db_in = 8'h37; ime = 1; irq_pending = 5'b00100; tick();
    check("cb opcode", int'(opcode), 'h37);
    check("cb mode", int'(cb_mode), 1);
    check("cb no dispatch", int'(irq_dispatch), 0);
    tick();
    check("dispatch vec", int'(irq_vec), 'h50);
    check("dispatch ack", int'(irq_ack), 'b00100);
    check("dispatch opcode", int'(opcode), 'hD3);
    done = 0; irq_pending = '0; tick();
    check("ack one cycle", int'(irq_ack), 0);

    // HALT entry, hold, and exit without IME.
    done = 1; ime = 0; db_in = 8'h76; tick();
    tick();
    check("halt entered", int'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      done = 1'($urandom); is_cond = 1'($urandom); tick();
    end
    check("halt held", int'(halted), 1);
    done = 0; is_cond = 0; irq_pending = 5'b00001; tick();
    check("halt exit", int'(halted), 0);
    check("halt exit opcode", int'(opcode), 'h00);
    check("halt exit ack", int'(irq_ack), 0);
    irq_pending = '0;

    // Stall holds, release fetches once.
    done = 1; db_in = 8'hAA; stall = 1;
    for (int i = 0; i < 3; i++) tick();
    check("stall hold", int'(opcode), 'h00);
    stall = 0; tick();
    check("stall release", int'(opcode), 'hAA);

    // Overrun from step 0.
    done = 0; db_in = 8'h5A;
    for (int i = 0; i < MAX_STEP; i++) tick();
    check("overrun step max", int'(step), MAX_STEP);
    tick();
    check("overrun illegal", int'(illegal), 1);
    check("overrun step", int'(step), 0);
    check("overrun fetch", int'(opcode), 'h5A);

    // Reset overrides stall.
    stall = 1; rst_n = 0; tick();
    check("rst stall illegal", int'(illegal), 0);
    check("rst stall opcode", int'(opcode), 'h00);
    rst_n = 1; stall = 0;

    for (int c = 0; c < 4000; c++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      stall       = ($urandom_range(0, 7) == 0);
      done        = ($urandom_range(0, 2) == 0);
      is_cond     = ($urandom_range(0, 3) == 0);
      next_cond   = STEP_W'($urandom);
      flags       = 4'($urandom);
      ime         = 1'($urandom);
      irq_pending = ($urandom_range(0, 5) == 0) ? IRQ_N'($urandom) : '0;
      db_in       = ($urandom_range(0, 1) == 0) ? picks[$urandom_range(0, 5)] : 8'($urandom);
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
